sync_pix_counter: RTL and testbench



---
 rtl/sync_pix_counter_if.sv | 25 ++
 rtl/sync_pix_counter.sv | 55 +++++
 tb/tb_sync_pix_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sync_pix_counter_if.sv
// Count strobe and registered timing outputs of one sync/pixel counter stage.
// ENABLE is a plain strobe with no back-pressure; the outputs are valid every cycle.
interface sync_pix_counter_if #(
   parameter int Size        = 10,
   parameter int AddressSize = 10
);
   logic                   ENABLE;
   logic                   TRIGGER_OUT;
   logic [Size-1:0]        TIME_COUNT;
   logic [AddressSize-1:0] PIXCOUNT;

   modport master (
      output ENABLE,
      input  TRIGGER_OUT,
      input  TIME_COUNT,
      input  PIXCOUNT
   );

   modport slave (
      input  ENABLE,
      output TRIGGER_OUT,
      output TIME_COUNT,
      output PIXCOUNT
   );
endinterface

// File: rtl/sync_pix_counter.sv
// Modulo-(MaxValue+1) sync-time counter with a one-cycle wrap trigger and a pixel
// address counter that runs only inside the visible window [BackPorchEnd, DisplayEnd).
module sync_pix_counter #(
   parameter int Size                 = 10,
   parameter int MaxValue             = 799,
   parameter int AddressSize          = 10,
   parameter int TimeToBackPorchEnd   = 143,
   parameter int TimeToDisplayTimeEnd = 783
) (
   input  logic                CLK,
   input  logic                RESET,
   sync_pix_counter_if.slave   bus
);

   localparam logic [Size-1:0] MAX_C = Size'(MaxValue);
   localparam logic [Size-1:0] BP_C  = Size'(TimeToBackPorchEnd);
   localparam logic [Size-1:0] DE_C  = Size'(TimeToDisplayTimeEnd);

   logic [Size-1:0]        time_q, time_d;
   logic                   trig_q, trig_d;
   logic [AddressSize-1:0] pix_q, pix_d;
   logic                   at_max;
   logic                   in_window;

   // Window test uses the pre-edge time, so PIXCOUNT lags TIME_COUNT-BackPorchEnd by zero.
   always_comb begin
      at_max    = (time_q == MAX_C);
      in_window = (time_q >= BP_C) && (time_q < DE_C);
      time_d    = time_q;
      pix_d     = pix_q;
      trig_d    = 1'b0;
      if (bus.ENABLE) begin
         trig_d = at_max;
         time_d = at_max ? '0 : time_q + 1'b1;
         pix_d  = in_window ? pix_q + 1'b1 : '0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         time_q <= '0;
         trig_q <= 1'b0;
         pix_q  <= '0;
      end else begin
         time_q <= time_d;
         trig_q <= trig_d;
         pix_q  <= pix_d;
      end
   end

   assign bus.TIME_COUNT  = time_q;
   assign bus.TRIGGER_OUT = trig_q;
   assign bus.PIXCOUNT    = pix_q;

endmodule

// File: tb/tb_sync_pix_counter.sv
// Bench for sync_pix_counter: default horizontal stage, chained vertical stage and a
// tiny configuration, checked through per-stage expected queues.
module tb_sync_pix_counter;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;
   int k_h    = 0;

   logic [20:0] exp_h_q[$];
   logic [5:0]  exp_s_q[$];

   sync_pix_counter_if #(.Size(10), .AddressSize(10)) h_if ();
   sync_pix_counter_if #(.Size(10), .AddressSize(9))  v_if ();
   sync_pix_counter_if #(.Size(3),  .AddressSize(2))  s_if ();

   assign v_if.ENABLE = h_if.TRIGGER_OUT;

   sync_pix_counter dut_h (
      .CLK   (clk),
      .RESET (rst),
      .bus   (h_if.slave)
   );

   sync_pix_counter #(
      .Size(10), .MaxValue(520), .AddressSize(9),
      .TimeToBackPorchEnd(31), .TimeToDisplayTimeEnd(511)
   ) dut_v (
      .CLK   (clk),
      .RESET (rst),
      .bus   (v_if.slave)
   );

   sync_pix_counter #(
      .Size(3), .MaxValue(4), .AddressSize(2),
      .TimeToBackPorchEnd(1), .TimeToDisplayTimeEnd(4)
   ) dut_s (
      .CLK   (clk),
      .RESET (rst),
      .bus   (s_if.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected horizontal state after k enabled edges since reset.
   function automatic logic [20:0] exp_h(input int k, input logic en);
      int t;
      logic tr;
      logic [9:0] p;
      t  = k % 800;
      tr = en && (t == 0) && (k > 0);
      p  = (t >= 144 && t <= 783) ? 10'(t - 143) : 10'd0;
      return {tr, 10'(t), p};
   endfunction

   // drivers
   task automatic drive_h(input logic en);
      @(negedge clk);
      h_if.ENABLE = en;
      if (en) k_h++;
      exp_h_q.push_back(exp_h(k_h, en));
   endtask

   task automatic drive_s(input logic en, input logic [5:0] exp);
      @(negedge clk);
      s_if.ENABLE = en;
      exp_s_q.push_back(exp);
   endtask

   // monitors
   always @(posedge clk) begin
      logic [20:0] e;
      #1;
      if (exp_h_q.size() > 0) begin
         e = exp_h_q.pop_front();
         check("h_trigger", 32'(h_if.TRIGGER_OUT), 32'(e[20]));
         check("h_time",    32'(h_if.TIME_COUNT),  32'(e[19:10]));
         check("h_pix",     32'(h_if.PIXCOUNT),    32'(e[9:0]));
      end
   end

   always @(posedge clk) begin
      logic [5:0] e;
      #1;
      if (exp_s_q.size() > 0) begin
         e = exp_s_q.pop_front();
         check("s_trigger", 32'(s_if.TRIGGER_OUT), 32'(e[5]));
         check("s_time",    32'(s_if.TIME_COUNT),  32'(e[4:2]));
         check("s_pix",     32'(s_if.PIXCOUNT),    32'(e[1:0]));
      end
   end

   // stimulus
   initial begin
      logic       s_en  [12];
      logic [5:0] s_exp [12];
      // {trigger, time[2:0], pix[1:0]} after each edge
      s_en  = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      s_exp = '{{1'b0, 3'd1, 2'd0}, {1'b0, 3'd2, 2'd1}, {1'b0, 3'd2, 2'd1},
                {1'b0, 3'd3, 2'd2}, {1'b0, 3'd4, 2'd3}, {1'b1, 3'd0, 2'd0},
                {1'b0, 3'd0, 2'd0}, {1'b0, 3'd1, 2'd0}, {1'b0, 3'd2, 2'd1},
                {1'b0, 3'd3, 2'd2}, {1'b0, 3'd4, 2'd3}, {1'b1, 3'd0, 2'd0}};

      rst = 1'b1;
      h_if.ENABLE = 1'b0;
      s_if.ENABLE = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_h_time", 32'(h_if.TIME_COUNT),  32'd0);
      check("rst_h_trig", 32'(h_if.TRIGGER_OUT), 32'd0);
      check("rst_h_pix",  32'(h_if.PIXCOUNT),    32'd0);
      check("rst_s_time", 32'(s_if.TIME_COUNT),  32'd0);
      rst = 1'b0;

      // two full lines: wrap, trigger and pixel window
      for (int i = 0; i < 1600; i++) drive_h(1'b1);

      // sparse enable, one strobe in four
      for (int i = 0; i < 3200; i++) drive_h(i % 4 == 3);
      drive_h(1'b0);
      drive_h(1'b0);
      @(posedge clk);
      #2;
      check("v_time_after_3_lines", 32'(v_if.TIME_COUNT),  32'd3);
      check("v_trig_idle",          32'(v_if.TRIGGER_OUT), 32'd0);
      check("v_pix_in_vsync",       32'(v_if.PIXCOUNT),    32'd0);

      // async reset mid-line at TIME_COUNT=300
      for (int i = 0; i < 300; i++) drive_h(1'b1);
      @(posedge clk);
      #3;
      check("pre_rst_h_time", 32'(h_if.TIME_COUNT), 32'd300);
      rst = 1'b1;
      #1;
      check("async_h_time", 32'(h_if.TIME_COUNT),  32'd0);
      check("async_h_pix",  32'(h_if.PIXCOUNT),    32'd0);
      check("async_h_trig", 32'(h_if.TRIGGER_OUT), 32'd0);
      check("async_v_time", 32'(v_if.TIME_COUNT),  32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("held_h_time", 32'(h_if.TIME_COUNT), 32'd0);
         check("held_h_pix",  32'(h_if.PIXCOUNT),   32'd0);
      end
      @(negedge clk);
      h_if.ENABLE = 1'b0;
      rst = 1'b0;
      k_h = 0;
      for (int i = 0; i < 150; i++) drive_h(1'b1);
      drive_h(1'b0);

      // tiny configuration, including held (ENABLE=0) edges
      for (int i = 0; i < 12; i++) drive_s(s_en[i], s_exp[i]);
      drive_s(1'b0, {1'b0, 3'd0, 2'd0});

      @(posedge clk);
      #3;
      check("h_queue_drained", 32'(exp_h_q.size()), 32'd0);
      check("s_queue_drained", 32'(exp_s_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
